gamma_lut_ctrl: RTL and testbench

- Controller for the RAM-based per-channel gamma LUT used in the pixel pipeline's gamma stage.
- Owns the LUT write port and double-buffers the curves in two banks: a shadow bank the host writes and an active bank the pixel path reads.
- After reset it auto-fills the shadow bank with an identity curve. Host commits swap banks and latch the gamma enable only at a vsync leading edge, so a frame never mixes two curves.

---
 rtl/gamma_lut_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_gamma_lut_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_lut_ctrl.sv
// -----------------------------------------------------------------------------
// gamma_lut_ctrl
//
// Write-side controller for the double-banked, per-channel gamma LUT RAM.
// The pixel path reads the active bank. The host, or the identity fill that
// runs after reset, only ever writes the other (shadow) bank. A host commit
// swaps the banks and latches the gamma enable. The swap waits for the next
// vsync leading edge, so a frame never mixes two curves.
//
// Ports
//   i_clk          pixel clock, the only clock
//   i_rst          synchronous, active-high reset
//   i_vsync        vsync, already synchronous to i_clk (active level VS_POL)
//   i_wr_valid     host LUT write request
//   o_wr_ready     write accepted when i_wr_valid && o_wr_ready
//   i_wr_ch        channel: 0=R, 1=G, 2=B, 3=invalid
//   i_wr_addr      LUT index
//   i_wr_data      LUT entry
//   i_commit       single-cycle pulse requesting a bank swap at the next frame
//   i_cfg_en       requested gamma enable, sampled on an accepted commit
//   o_busy         high while filling, waiting for vsync, or swapping
//   o_swap_done    one-cycle pulse in the cycle after a bank swap
//   o_err          sticky: an accepted write used channel 3
//   o_lut_we       LUT RAM write enable (registered)
//   o_lut_bank     bank being written; always the shadow bank
//   o_lut_ch       channel being written
//   o_lut_addr     address being written
//   o_lut_wdata    data being written
//   o_active_bank  bank the pixel path reads
//   o_gamma_en     pixel-path enable (selects post-LUT data)
//
// DATA_W must be >= ADDR_W, because the identity fill writes wdata = addr.
// -----------------------------------------------------------------------------
module gamma_lut_ctrl #(
  parameter logic VS_POL = 1'b1,
  parameter int   ADDR_W = 8,
  parameter int   DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vsync,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [1:0]        i_wr_ch,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_commit,
  input  logic              i_cfg_en,
  output logic              o_busy,
  output logic              o_swap_done,
  output logic              o_err,
  output logic              o_lut_we,
  output logic              o_lut_bank,
  output logic [1:0]        o_lut_ch,
  output logic [ADDR_W-1:0] o_lut_addr,
  output logic [DATA_W-1:0] o_lut_wdata,
  output logic              o_active_bank,
  output logic              o_gamma_en
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_PEND = 2'd2,
    ST_SWAP = 2'd3
  } state_t;

  localparam logic [1:0] CH_LAST = 2'd2;
  localparam logic [1:0] CH_BAD  = 2'd3;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_fill_ch;
  logic [ADDR_W-1:0] r_fill_addr;
  logic              r_vs_d;
  logic              r_commit_pend;
  logic              r_en_shadow;

  logic              w_vs_rise;
  logic              w_wr_fire;
  logic              w_fill_last;

  // vs_d resets to the active level, so a vsync held active through reset
  // does not count as a leading edge.
  assign w_vs_rise   = (i_vsync == VS_POL) && (r_vs_d != VS_POL);
  assign w_wr_fire   = i_wr_valid && o_wr_ready;
  assign w_fill_last = (r_fill_ch == CH_LAST) && (r_fill_addr == '1);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments, so all
  // registers sample values from before the edge, whatever order they are
  // evaluated in.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake/status outputs
  // ---------------------------------------------------------------------------
  // NOTE: each output of this block is assigned a default before the case
  // statement, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    o_wr_ready  = 1'b0;
    o_busy      = 1'b1;
    unique case (r_state)
      ST_INIT: begin
        // PEND always follows the fill. The identity bank is swapped in at
        // the first frame, together with any commit made during the fill.
        if (w_fill_last) w_state_nxt = ST_PEND;
      end
      ST_IDLE: begin
        o_wr_ready = 1'b1;
        o_busy     = 1'b0;
        if (i_commit) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_vs_rise) w_state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Identity-fill walker: channel is the outer loop, address the inner loop
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fill_ch   <= 2'd0;
      r_fill_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_fill_addr <= r_fill_addr + 1'b1;
      if (w_fill_last)              r_fill_ch <= 2'd0;
      else if (r_fill_addr == '1)   r_fill_ch <= r_fill_ch + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered LUT write port. Only the shadow bank is written, so the bank
  // select comes from o_lut_bank and does not depend on the request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lut_we    <= 1'b0;
      o_lut_ch    <= 2'd0;
      o_lut_addr  <= '0;
      o_lut_wdata <= '0;
    end else begin
      o_lut_we <= 1'b0;
      if (r_state == ST_INIT) begin
        o_lut_we    <= 1'b1;
        o_lut_ch    <= r_fill_ch;
        o_lut_addr  <= r_fill_addr;
        o_lut_wdata <= DATA_W'(r_fill_addr);
      end else if (w_wr_fire && (i_wr_ch != CH_BAD)) begin
        o_lut_we    <= 1'b1;
        o_lut_ch    <= i_wr_ch;
        o_lut_addr  <= i_wr_addr;
        o_lut_wdata <= i_wr_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank/enable control, vsync history, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vs_d        <= VS_POL;
      o_active_bank <= 1'b1;
      o_lut_bank    <= 1'b0;
      o_gamma_en    <= 1'b0;
      o_swap_done   <= 1'b0;
      o_err         <= 1'b0;
      r_commit_pend <= 1'b0;
      r_en_shadow   <= 1'b0;
    end else begin
      r_vs_d      <= i_vsync;
      o_swap_done <= (r_state == ST_SWAP);
      if (w_wr_fire && (i_wr_ch == CH_BAD)) o_err <= 1'b1;

      unique case (r_state)
        ST_INIT: begin
          // Only the first commit during the fill samples cfg_en. Later
          // pulses are covered by the same single swap.
          if (i_commit && !r_commit_pend) begin
            r_commit_pend <= 1'b1;
            r_en_shadow   <= i_cfg_en;
          end
        end
        ST_IDLE: begin
          if (i_commit) r_en_shadow <= i_cfg_en;
        end
        ST_SWAP: begin
          o_active_bank <= ~o_active_bank;
          o_lut_bank    <= o_active_bank;
          o_gamma_en    <= r_en_shadow;
          r_commit_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gamma_lut_ctrl
//
// Scoreboard bench for gamma_lut_ctrl. The stimulus process keeps a small
// frame-level model of the controller: which bank is active, whether a commit
// is waiting, the gamma enable it carries, and the sticky error. It pushes
// every LUT write and every bank swap it expects into queues. A separate
// monitor samples the DUT on the falling edge and pops and compares entries
// whenever lut_we or swap_done is high.
// A second instance with VS_POL=0 shares the inputs and gets directed checks
// for the falling-edge swap.
// -----------------------------------------------------------------------------
module tb_gamma_lut_ctrl;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int NENT = 1 << AW;
  localparam int FILL = 3 * NENT;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          vsync = 1'b0;
  logic          wr_valid = 1'b0;
  logic [1:0]    wr_ch = 2'd0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          commit = 1'b0;
  logic          cfg_en = 1'b0;

  logic          wr_ready, busy, swap_done, err, lut_we, lut_bank;
  logic [1:0]    lut_ch;
  logic [AW-1:0] lut_addr;
  logic [DW-1:0] lut_wdata;
  logic          active_bank, gamma_en;

  logic          z_wr_ready, z_busy, z_swap_done, z_err, z_lut_we, z_lut_bank;
  logic [1:0]    z_lut_ch;
  logic [AW-1:0] z_lut_addr;
  logic [DW-1:0] z_lut_wdata;
  logic          z_active_bank, z_gamma_en;

  gamma_lut_ctrl #(.VS_POL(1'b1), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_vsync(vsync),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_ch(wr_ch),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_commit(commit), .i_cfg_en(cfg_en),
    .o_busy(busy), .o_swap_done(swap_done), .o_err(err),
    .o_lut_we(lut_we), .o_lut_bank(lut_bank), .o_lut_ch(lut_ch),
    .o_lut_addr(lut_addr), .o_lut_wdata(lut_wdata),
    .o_active_bank(active_bank), .o_gamma_en(gamma_en)
  );

  gamma_lut_ctrl #(.VS_POL(1'b0), .ADDR_W(AW), .DATA_W(DW)) u_dut_vs0 (
    .i_clk(clk), .i_rst(rst), .i_vsync(vsync),
    .i_wr_valid(wr_valid), .o_wr_ready(z_wr_ready), .i_wr_ch(wr_ch),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_commit(commit), .i_cfg_en(cfg_en),
    .o_busy(z_busy), .o_swap_done(z_swap_done), .o_err(z_err),
    .o_lut_we(z_lut_we), .o_lut_bank(z_lut_bank), .o_lut_ch(z_lut_ch),
    .o_lut_addr(z_lut_addr), .o_lut_wdata(z_lut_wdata),
    .o_active_bank(z_active_bank), .o_gamma_en(z_gamma_en)
  );

  typedef struct packed {
    logic          bank;
    logic [1:0]    ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic bank;
    logic gamma;
  } sw_t;

  wr_t exp_wr[$];
  sw_t exp_sw[$];

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model of the VS_POL=1 instance.
  logic m_active, m_gamma, m_en, m_pend, m_err, m_vs, m_init_commit;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pop and compare on every LUT write and every swap pulse
  // ---------------------------------------------------------------------------
  wr_t mon_wr;
  wr_t mon_exp_wr;
  sw_t mon_exp_sw;

  initial begin
    forever begin
      @(negedge clk);
      if (lut_we === 1'b1) begin
        mon_wr = {lut_bank, lut_ch, lut_addr, lut_wdata};
        if (exp_wr.size() == 0) begin
          check("lut_we_unexpected", 32'd0, 32'd1);
        end else begin
          mon_exp_wr = exp_wr.pop_front();
          check("lut_write", 32'(mon_wr), 32'(mon_exp_wr));
        end
      end
      if (swap_done === 1'b1) begin
        if (exp_sw.size() == 0) begin
          check("swap_unexpected", 32'd0, 32'd1);
        end else begin
          mon_exp_sw = exp_sw.pop_front();
          check("swap_bank_gamma", 32'({active_bank, gamma_en}), 32'(mon_exp_sw));
          check("swap_lut_bank", 32'(lut_bank), 32'(!active_bank));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------

  // Called one step after a reset edge with rst still high: check the reset
  // state, load the expected identity fill and release reset.
  task automatic post_reset();
    check("rst_wr_ready",  32'(wr_ready),    32'd0);
    check("rst_busy",      32'(busy),        32'd1);
    check("rst_swap_done", 32'(swap_done),   32'd0);
    check("rst_err",       32'(err),         32'd0);
    check("rst_lut_we",    32'(lut_we),      32'd0);
    check("rst_lut_ch",    32'(lut_ch),      32'd0);
    check("rst_lut_addr",  32'(lut_addr),    32'd0);
    check("rst_lut_wdata", 32'(lut_wdata),   32'd0);
    check("rst_active",    32'(active_bank), 32'd1);
    check("rst_lut_bank",  32'(lut_bank),    32'd0);
    check("rst_gamma",     32'(gamma_en),    32'd0);
    check("rst_vs0_active", 32'(z_active_bank), 32'd1);
    exp_wr.delete();
    exp_sw.delete();
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < NENT; a++)
        exp_wr.push_back({1'b0, 2'(c), AW'(a), DW'(a)});
    m_active      = 1'b1;
    m_gamma       = 1'b0;
    m_en          = 1'b0;
    m_pend        = 1'b1;
    m_err         = 1'b0;
    m_init_commit = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    post_reset();
  endtask

  // Run the fill while counting consecutive lut_we cycles. Optionally pulse
  // commit (cfg_en=1) or assert rst at a given fill cycle. Bounded loop.
  task automatic run_fill(input int commit_at, input int rst_at, output int run);
    run = 0;
    for (int i = 0; i < FILL + 50; i++) begin
      commit = (i == commit_at);
      cfg_en = (i == commit_at);
      if (i == commit_at && !m_init_commit) begin
        m_en = 1'b1;
        m_init_commit = 1'b1;
      end
      if (i == rst_at) rst = 1'b1;
      tick();
      if (i == rst_at) break;
      if (lut_we) run++;
      else if (run > 0) break;
    end
    commit = 1'b0;
    cfg_en = 1'b0;
  endtask

  task automatic set_vs(input logic v);
    vsync = v;
    if (v && !m_vs && m_pend) begin
      exp_sw.push_back({~m_active, m_en});
      m_active = ~m_active;
      m_gamma  = m_en;
      m_pend   = 1'b0;
    end
    m_vs = v;
  endtask

  // Called right after set_vs() has driven the leading edge for a pending
  // commit: SWAP in the next cycle, then the new bank and the pulse.
  task automatic expect_swap();
    tick();
    check("swap_not_early", 32'(swap_done),   32'd0);
    check("busy_in_swap",   32'(busy),        32'd1);
    check("active_held",    32'(active_bank), 32'(!m_active));
    tick();
    check("swap_pulse",     32'(swap_done),   32'd1);
    check("active_new",     32'(active_bank), 32'(m_active));
    check("gamma_new",      32'(gamma_en),    32'(m_gamma));
    check("idle_ready",     32'(wr_ready),    32'd1);
    tick();
    check("swap_pulse_end", 32'(swap_done),   32'd0);
    check("swap_consumed",  32'(exp_sw.size()), 32'd0);
  endtask

  // One input cycle: optional write, optional commit. The model decides
  // acceptance from wr_ready, which is stable until the next edge.
  task automatic issue(input logic v, input logic [1:0] ch, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic cm, input logic ce);
    wr_valid = v;
    wr_ch    = ch;
    wr_addr  = a;
    wr_data  = d;
    commit   = cm;
    cfg_en   = ce;
    if (v && wr_ready) begin
      if (ch != 2'd3) exp_wr.push_back({~m_active, ch, a, d});
      else            m_err = 1'b1;
    end
    if (cm && wr_ready) begin
      m_en   = ce;
      m_pend = 1'b1;
    end
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
    cfg_en   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int run;
    logic [1:0] rch;
    logic       rce;

    m_vs = 1'b0;

    // Power-up fill, then the first swap at a vsync leading edge.
    do_reset();
    run_fill(-1, -1, run);
    check("fill_len", 32'(run), 32'(FILL));
    repeat (220) tick();
    check("pend_busy",  32'(busy),     32'd1);
    check("pend_ready", 32'(wr_ready), 32'd0);
    set_vs(1'b1);
    expect_swap();
    check("first_gamma", 32'(gamma_en), 32'd0);
    set_vs(1'b0);
    tick();

    // Host write lands in the shadow bank one cycle after the handshake.
    issue(1'b1, 2'd1, 8'h40, 8'h7F, 1'b0, 1'b0);
    check("wr_lut_we",   32'(lut_we),    32'd1);
    check("wr_lut_bank", 32'(lut_bank),  32'd1);
    check("wr_lut_ch",   32'(lut_ch),    32'd1);
    check("wr_lut_addr", 32'(lut_addr),  32'h40);
    check("wr_lut_data", 32'(lut_wdata), 32'h7F);
    tick();

    // Invalid channel: no write, sticky error.
    issue(1'b1, 2'd3, 8'h12, 8'h34, 1'b0, 1'b0);
    check("bad_ch_no_we", 32'(lut_we), 32'd0);
    check("bad_ch_err",   32'(err),    32'd1);
    issue(1'b1, 2'd0, 8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    check("err_sticky_wr", 32'(err), 32'd1);

    // Commit while vsync is already active: no swap until the next edge.
    set_vs(1'b1);
    tick();
    issue(1'b0, 2'd0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) begin
        check("held_ready", 32'(wr_ready),  32'd0);
        check("held_noswp", 32'(swap_done), 32'd0);
      end
      tick();
    end
    check("held_active", 32'(active_bank), 32'd0);
    set_vs(1'b0);
    tick();
    tick();
    set_vs(1'b1);
    expect_swap();
    check("held_gamma",     32'(gamma_en), 32'd1);
    check("err_sticky_swp", 32'(err),      32'd1);

    // Randomized frames: host writes, a commit with random enable, a swap.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          rch = ($urandom_range(0, 7) == 7) ? 2'd3 : 2'($urandom_range(0, 2));
          issue(1'b1, rch, AW'($urandom), DW'($urandom), 1'b0, 1'b0);
        end else begin
          tick();
        end
      end
      rce = 1'($urandom_range(0, 1));
      rch = 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), rch, AW'($urandom), DW'($urandom), 1'b1, rce);
      set_vs(1'b0);
      repeat ($urandom_range(1, 6)) tick();
      set_vs(1'b1);
      expect_swap();
      check("rand_err", 32'(err), 32'(m_err));
    end
    set_vs(1'b0);

    // Commit during the fill: one swap afterwards, carrying cfg_en=1.
    do_reset();
    run_fill(100, -1, run);
    check("fill_len_cmt", 32'(run), 32'(FILL));
    tick();
    set_vs(1'b1);
    expect_swap();
    check("init_cmt_gamma", 32'(gamma_en), 32'd1);
    set_vs(1'b0);
    repeat (3) tick();
    set_vs(1'b1);
    repeat (5) tick();
    check("init_cmt_single", 32'(active_bank), 32'd0);
    set_vs(1'b0);

    // Reset in the middle of the fill: lut_we drops and the fill restarts.
    do_reset();
    run_fill(-1, 300, run);
    check("fill_cut", 32'(run), 32'd300);
    post_reset();
    run_fill(-1, -1, run);
    check("fill_len_restart", 32'(run), 32'(FILL));

    // VS_POL=0 instance: swaps on the falling edge only.
    tick();
    set_vs(1'b1);
    expect_swap();
    check("vs0_no_rise_swap", 32'(z_active_bank), 32'd1);
    set_vs(1'b0);
    tick();
    check("vs0_pre_swap", 32'(z_swap_done), 32'd0);
    tick();
    check("vs0_swap1",   32'(z_swap_done),   32'd1);
    check("vs0_active1", 32'(z_active_bank), 32'd0);
    tick();
    issue(1'b1, 2'd2, 8'hA5, 8'h3C, 1'b1, 1'b1);
    check("vs0_wr_we",   32'(z_lut_we),    32'd1);
    check("vs0_wr_bank", 32'(z_lut_bank),  32'd1);
    check("vs0_wr_ch",   32'(z_lut_ch),    32'd2);
    check("vs0_wr_addr", 32'(z_lut_addr),  32'hA5);
    check("vs0_wr_data", 32'(z_lut_wdata), 32'h3C);
    check("vs0_pend_ready", 32'(z_wr_ready), 32'd0);
    set_vs(1'b1);
    expect_swap();
    repeat (3) tick();
    check("vs0_rise_noswap", 32'(z_swap_done),   32'd0);
    check("vs0_rise_active", 32'(z_active_bank), 32'd0);
    set_vs(1'b0);
    tick();
    check("vs0_busy_swap", 32'(z_busy), 32'd1);
    tick();
    check("vs0_swap2",   32'(z_swap_done),   32'd1);
    check("vs0_active2", 32'(z_active_bank), 32'd1);
    check("vs0_gamma2",  32'(z_gamma_en),    32'd1);
    repeat (3) tick();

    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("sw_queue_empty", 32'(exp_sw.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
